mem_port_arbiter: RTL and testbench

// - Shares the single unified memory port between instruction fetch (IF) and load/store (LS) of the multi-cycle core.
// - Each requester uses a req/ack handshake. Memory uses req/ready with variable latency.
// - Adds LS-priority arbitration with an IF starvation guard, a memory timeout and IF misalignment trapping.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_timer.sv | 32 +++
 rtl/mem_port_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory port arbiter: FSM states, owner tags
// and the byte-enable pattern used for instruction fetches.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_t;

   localparam logic [3:0] FULL_BE = 4'hF;

endpackage

// File: rtl/mem_arb_timer.sv
// Access watchdog: counts cycles spent waiting on the memory and flags the
// cycle in which the wait reaches TIMEOUT_CYC.
module mem_arb_timer #(
   parameter int TIMEOUT_CYC = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] wait_cnt;

   // The current cycle is counted before the register updates, so the
   // TIMEOUT_CYC-th waiting cycle is the one where wait_cnt holds TIMEOUT_CYC-1.
   assign expired = en && (wait_cnt == LAST_CNT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if (clr) begin
         wait_cnt <= '0;
      end else if (en && !expired) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store: LS has
// priority, IF is forced after MAX_LS_RUN LS grants while it waits.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 16,
   parameter int MAX_LS_RUN  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic              if_err,
   output logic [31:0]       if_rdata,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [3:0]        ls_be,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [31:0]       ls_wdata,
   output logic              ls_ack,
   output logic              ls_err,
   output logic [31:0]       ls_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic              busy
);

   localparam int RUN_W = $clog2(MAX_LS_RUN + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_LS_RUN);

   state_t           state;
   state_t           state_nxt;
   owner_t           owner;
   logic [RUN_W-1:0] ls_run;

   logic grant_ls;
   logic grant_if;
   logic if_misalign;
   logic start_ls;
   logic start_if;
   logic trap_if;
   logic done_ok;
   logic done_to;
   logic tmr_clr;
   logic tmr_en;
   logic tmr_expired;
   logic if_done;
   logic ls_done;

   assign if_misalign = (if_addr[1:0] != 2'b00);
   assign grant_ls    = ls_req && !(if_req && (ls_run == RUN_MAX));
   assign grant_if    = if_req && !grant_ls;

   assign tmr_clr = (state != ACCESS);
   assign tmr_en  = (state == ACCESS);

   mem_arb_timer #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (tmr_clr),
      .en     (tmr_en),
      .expired(tmr_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      start_ls  = 1'b0;
      start_if  = 1'b0;
      trap_if   = 1'b0;
      done_ok   = 1'b0;
      done_to   = 1'b0;
      case (state)
         IDLE: begin
            if (grant_ls) begin
               start_ls  = 1'b1;
               state_nxt = ACCESS;
            end else if (grant_if) begin
               // A misaligned fetch never reaches memory; it is answered directly.
               if (if_misalign) begin
                  trap_if   = 1'b1;
                  state_nxt = RESP;
               end else begin
                  start_if  = 1'b1;
                  state_nxt = ACCESS;
               end
            end
         end
         ACCESS: begin
            // A late mem_ready in the final waiting cycle still wins over the timeout.
            if (mem_ready) begin
               done_ok   = 1'b1;
               state_nxt = RESP;
            end else if (tmr_expired) begin
               done_to   = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign if_done = (done_ok || done_to) && (owner == OWN_IF);
   assign ls_done = (done_ok || done_to) && (owner == OWN_LS);
   assign busy    = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner  <= OWN_IF;
         ls_run <= '0;
      end else if (start_ls) begin
         owner <= OWN_LS;
         if (if_req && (ls_run != RUN_MAX)) begin
            ls_run <= ls_run + 1'b1;
         end
      end else if (start_if || trap_if) begin
         owner  <= OWN_IF;
         ls_run <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_be    <= 4'h0;
         mem_addr  <= '0;
         mem_wdata <= 32'h0;
      end else if (start_ls) begin
         mem_req   <= 1'b1;
         mem_we    <= ls_we;
         mem_be    <= ls_be;
         mem_addr  <= ls_addr;
         mem_wdata <= ls_wdata;
      end else if (start_if) begin
         mem_req   <= 1'b1;
         mem_we    <= 1'b0;
         mem_be    <= FULL_BE;
         mem_addr  <= if_addr;
         mem_wdata <= 32'h0;
      end else if (done_ok || done_to) begin
         mem_req <= 1'b0;
      end
   end

   // Response registers: acks pulse for the single RESP cycle, data/err hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_ack   <= 1'b0;
         if_err   <= 1'b0;
         if_rdata <= 32'h0;
         ls_ack   <= 1'b0;
         ls_err   <= 1'b0;
         ls_rdata <= 32'h0;
      end else begin
         if_ack <= if_done || trap_if;
         ls_ack <= ls_done;
         if (trap_if) begin
            if_err   <= 1'b1;
            if_rdata <= 32'h0;
         end else if (if_done) begin
            if_err   <= done_to;
            if_rdata <= done_ok ? mem_rdata : 32'h0;
         end
         if (ls_done) begin
            ls_err   <= done_to;
            ls_rdata <= done_ok ? mem_rdata : 32'h0;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a latency-programmable memory
// responder and hand-computed expectations.
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ack;
   logic        if_err;
   logic [31:0] if_rdata;
   logic        ls_req;
   logic        ls_we;
   logic [3:0]  ls_be;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic        ls_ack;
   logic        ls_err;
   logic [31:0] ls_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        busy;

   int n_chk;
   int n_fail;

   int          mem_lat;
   int          mem_cnt;
   logic [31:0] mem_val;

   mem_port_arbiter #(
      .ADDR_W     (32),
      .TIMEOUT_CYC(16),
      .MAX_LS_RUN (4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_ack   (if_ack),
      .if_err   (if_err),
      .if_rdata (if_rdata),
      .ls_req   (ls_req),
      .ls_we    (ls_we),
      .ls_be    (ls_be),
      .ls_addr  (ls_addr),
      .ls_wdata (ls_wdata),
      .ls_ack   (ls_ack),
      .ls_err   (ls_err),
      .ls_rdata (ls_rdata),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .mem_be   (mem_be),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_ready(mem_ready),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: ready in the (mem_lat+1)-th cycle of mem_req; never if mem_lat < 0.
   always @(negedge clk) begin
      if (!rst_n || !mem_req) begin
         mem_cnt   = 0;
         mem_ready = 1'b0;
         mem_rdata = 32'h0;
      end else begin
         mem_cnt = mem_cnt + 1;
         if (mem_lat >= 0 && mem_cnt == mem_lat + 1) begin
            mem_ready = 1'b1;
            mem_rdata = mem_val;
         end else begin
            mem_ready = 1'b0;
            mem_rdata = 32'h0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (obs !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(input bit is_ls, input int max_cyc, output int cyc, output int req_cyc);
      cyc     = 0;
      req_cyc = 0;
      forever begin
         step();
         cyc = cyc + 1;
         if (mem_req) req_cyc = req_cyc + 1;
         if (is_ls ? ls_ack : if_ack) break;
         if (cyc >= max_cyc) begin
            chk(is_ls ? "ls_ack_timeout" : "if_ack_timeout", 32'(cyc), 32'(max_cyc + 1));
            break;
         end
      end
   endtask

   initial begin
      int cyc;
      int req_cyc;
      int nseq;
      int nls;
      int seq [6];

      n_chk    = 0;
      n_fail   = 0;
      mem_lat  = -1;
      mem_val  = 32'h0;
      rst_n    = 1'b0;
      if_req   = 1'b0;
      if_addr  = 32'h0;
      ls_req   = 1'b0;
      ls_we    = 1'b0;
      ls_be    = 4'h0;
      ls_addr  = 32'h0;
      ls_wdata = 32'h0;

      step();
      step();
      chk("rst_mem_req", 32'(mem_req), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_if_ack", 32'(if_ack), 0);
      chk("rst_ls_ack", 32'(ls_ack), 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_mem_addr", mem_addr, 0);
      rst_n = 1'b1;
      step();

      // IF only, memory answers 3 cycles after mem_req rises
      mem_lat = 3;
      mem_val = 32'hDEAD_BEEF;
      if_req  = 1'b1;
      if_addr = 32'h100;
      step();
      chk("t1_mem_req", 32'(mem_req), 1);
      chk("t1_mem_be", 32'(mem_be), 32'hF);
      chk("t1_mem_we", 32'(mem_we), 0);
      chk("t1_mem_addr", mem_addr, 32'h100);
      chk("t1_mem_wdata", mem_wdata, 0);
      chk("t1_busy", 32'(busy), 1);
      wait_ack(1'b0, 20, cyc, req_cyc);
      chk("t1_ack_cycle", 32'(cyc + 1), 5);
      chk("t1_req_cycles", 32'(1 + req_cyc), 4);
      chk("t1_if_rdata", if_rdata, 32'hDEAD_BEEF);
      chk("t1_if_err", 32'(if_err), 0);
      chk("t1_ls_ack", 32'(ls_ack), 0);
      if_req = 1'b0;
      step();
      chk("t1_busy_after", 32'(busy), 0);
      chk("t1_ack_pulse", 32'(if_ack), 0);

      // Simultaneous requests: LS store first, then IF in the next IDLE
      mem_lat  = 0;
      mem_val  = 32'h1111_2222;
      if_req   = 1'b1;
      if_addr  = 32'h104;
      ls_req   = 1'b1;
      ls_we    = 1'b1;
      ls_be    = 4'h3;
      ls_addr  = 32'h204;
      ls_wdata = 32'hA5A5_0001;
      step();
      chk("t2_mem_req", 32'(mem_req), 1);
      chk("t2_mem_we", 32'(mem_we), 1);
      chk("t2_mem_be", 32'(mem_be), 32'h3);
      chk("t2_mem_addr", mem_addr, 32'h204);
      chk("t2_mem_wdata", mem_wdata, 32'hA5A5_0001);
      wait_ack(1'b1, 20, cyc, req_cyc);
      chk("t2_ls_ack_cycle", 32'(cyc + 1), 2);
      chk("t2_if_ack_low", 32'(if_ack), 0);
      chk("t2_ls_err", 32'(ls_err), 0);
      chk("t2_ls_rdata", ls_rdata, 32'h1111_2222);
      chk("t2_if_rdata_hold", if_rdata, 32'hDEAD_BEEF);
      ls_req = 1'b0;
      ls_we  = 1'b0;
      step();
      chk("t2_idle_busy", 32'(busy), 0);
      step();
      chk("t2_if_mem_req", 32'(mem_req), 1);
      chk("t2_if_mem_addr", mem_addr, 32'h104);
      chk("t2_if_mem_be", 32'(mem_be), 32'hF);
      chk("t2_if_mem_wdata", mem_wdata, 0);
      wait_ack(1'b0, 20, cyc, req_cyc);
      chk("t2_if_ack_cycle", 32'(cyc), 1);
      if_req = 1'b0;
      step();

      // IF held while LS issues 5 back-to-back requests
      mem_lat = 1;
      mem_val = 32'h0000_0055;
      if_req  = 1'b1;
      if_addr = 32'h108;
      ls_req  = 1'b1;
      ls_be   = 4'hF;
      ls_addr = 32'h208;
      nseq    = 0;
      nls     = 0;
      for (int k = 0; k < 200 && nseq < 6; k++) begin
         step();
         if (ls_ack && nseq < 6) begin
            seq[nseq] = 1;
            nseq = nseq + 1;
            nls  = nls + 1;
            if (nls == 5) ls_req = 1'b0;
         end
         if (if_ack && nseq < 6) begin
            seq[nseq] = 2;
            nseq   = nseq + 1;
            if_req = 1'b0;
         end
      end
      chk("t3_ack_count", 32'(nseq), 6);
      for (int k = 0; k < 6; k++) begin
         if (k < nseq) chk($sformatf("t3_order%0d", k), 32'(seq[k]), (k == 4) ? 32'd2 : 32'd1);
      end
      if_req = 1'b0;
      ls_req = 1'b0;
      step();
      step();

      // Memory never ready: LS access times out
      mem_lat = -1;
      ls_req  = 1'b1;
      ls_we   = 1'b0;
      ls_addr = 32'h300;
      wait_ack(1'b1, 40, cyc, req_cyc);
      chk("t4_req_cycles", 32'(req_cyc), 16);
      chk("t4_ack_cycle", 32'(cyc), 17);
      chk("t4_mem_req_low", 32'(mem_req), 0);
      chk("t4_ls_err", 32'(ls_err), 1);
      chk("t4_ls_rdata", ls_rdata, 0);
      ls_req = 1'b0;
      step();
      chk("t4_busy_after", 32'(busy), 0);
      chk("t4_ls_err_hold", 32'(ls_err), 1);

      // Misaligned fetch trapped without touching memory
      mem_lat = 0;
      mem_val = 32'h7777_7777;
      if_req  = 1'b1;
      if_addr = 32'h102;
      wait_ack(1'b0, 10, cyc, req_cyc);
      chk("t5_ack_cycle", 32'(cyc + 1), 2);
      chk("t5_no_mem_req", 32'(req_cyc), 0);
      chk("t5_if_err", 32'(if_err), 1);
      chk("t5_if_rdata", if_rdata, 0);
      if_req = 1'b0;
      step();

      // Reset in the middle of an access, then re-grant after release
      mem_lat = -1;
      mem_val = 32'h4444_0400;
      if_req  = 1'b1;
      if_addr = 32'h400;
      step();
      step();
      step();
      chk("t6_in_access", 32'(mem_req), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_rst_mem_req", 32'(mem_req), 0);
      chk("t6_rst_busy", 32'(busy), 0);
      mem_lat = 2;
      step();
      chk("t6_rst_no_ack", 32'(if_ack), 0);
      rst_n = 1'b1;
      wait_ack(1'b0, 20, cyc, req_cyc);
      chk("t6_reack_cycle", 32'(cyc), 4);
      chk("t6_if_err", 32'(if_err), 0);
      chk("t6_if_rdata", if_rdata, 32'h4444_0400);
      if_req = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
